// File: rtl/booth_product_divider.sv
// Restoring signed divider: recovers the Booth array multiplier operand (quotient) and a
// remainder from a 2N-bit array product and the array's fixed multiplicand, one step per clock.
module booth_product_divider #(
    parameter int unsigned  N            = 32,
    parameter logic [N-1:0] MULTIPLICAND = 32'h5555_5555
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2*N-1:0]   product_i,
    output logic [2*N-1:0]   quotient_o,
    output logic [N-1:0]     remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned     CW          = $clog2(2 * N) + 1;
    localparam logic [CW-1:0]   LAST_ITER   = CW'(2 * N - 1);
    localparam logic [CW-1:0]   ONE_CW      = CW'(1);
    localparam logic [N-1:0]    ONE_N       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0]  ONE_2N      = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0]  MIN_2N      = {1'b1, {(2*N-1){1'b0}}};
    // 2^(N-1) maps onto itself, which is the correct unsigned magnitude
    localparam logic [N-1:0]    DIV_MAG     = MULTIPLICAND[N-1] ? (~MULTIPLICAND + ONE_N) : MULTIPLICAND;
    localparam logic            DIV_ZERO    = (MULTIPLICAND == {N{1'b0}});
    localparam logic            DIV_NEG_ONE = (MULTIPLICAND == {N{1'b1}});

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  acc_q;
    logic [N-1:0]    rem_q;
    logic [2*N-1:0]  prod_q;
    logic            sign_quo_q;
    logic            sign_rem_q;
    logic [2*N-1:0]  quotient_q;
    logic [N-1:0]    remainder_q;
    logic            busy_q;
    logic            done_q;
    logic            div_by_zero_q;
    logic            overflow_q;

    logic [N:0]      trial_s;
    logic            fits_s;
    logic [2*N-1:0]  prod_mag_s;
    logic [2*N-1:0]  acc_d;
    logic [N-1:0]    rem_d;
    logic [2*N-1:0]  quotient_d;
    logic [N-1:0]    remainder_d;
    logic            overflow_d;

    // Datapath: one restoring step, operand magnitude and the final sign/exception fix-up
    always_comb begin
        trial_s     = {rem_q, acc_q[2*N-1]};
        fits_s      = (trial_s >= {1'b0, DIV_MAG});
        acc_d       = {acc_q[2*N-2:0], fits_s};
        rem_d       = trial_s[N-1:0];
        prod_mag_s  = product_i;
        quotient_d  = acc_q;
        remainder_d = rem_q;
        overflow_d  = DIV_NEG_ONE && (prod_q == MIN_2N);

        // T < 2*|D| <= 2^N, so the difference always fits in N bits
        if (fits_s) begin
            rem_d = trial_s[N-1:0] - DIV_MAG;
        end else begin
            rem_d = trial_s[N-1:0];
        end

        if (product_i[2*N-1]) begin
            prod_mag_s = ~product_i + ONE_2N;
        end else begin
            prod_mag_s = product_i;
        end

        if (DIV_ZERO) begin
            quotient_d  = {(2*N){1'b1}};
            remainder_d = prod_q[N-1:0];
        end else if (overflow_d) begin
            quotient_d  = prod_q;
            remainder_d = {N{1'b0}};
        end else begin
            if (sign_quo_q) begin
                quotient_d = ~acc_q + ONE_2N;
            end else begin
                quotient_d = acc_q;
            end
            if (sign_rem_q) begin
                remainder_d = ~rem_q + ONE_N;
            end else begin
                remainder_d = rem_q;
            end
        end
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= {CW{1'b0}};
            acc_q         <= {(2*N){1'b0}};
            rem_q         <= {N{1'b0}};
            prod_q        <= {(2*N){1'b0}};
            sign_quo_q    <= 1'b0;
            sign_rem_q    <= 1'b0;
            quotient_q    <= {(2*N){1'b0}};
            remainder_q   <= {N{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        prod_q     <= product_i;
                        acc_q      <= prod_mag_s;
                        rem_q      <= {N{1'b0}};
                        cnt_q      <= {CW{1'b0}};
                        sign_quo_q <= product_i[2*N-1] ^ MULTIPLICAND[N-1];
                        sign_rem_q <= product_i[2*N-1];
                        busy_q     <= 1'b1;
                        state_q    <= DIV;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DIV: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + ONE_CW;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= DIV;
                    end
                end
                FIX: begin
                    quotient_q    <= quotient_d;
                    remainder_q   <= remainder_d;
                    div_by_zero_q <= DIV_ZERO;
                    overflow_q    <= overflow_d;
                    done_q        <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = div_by_zero_q;
    assign overflow_o    = overflow_q;

endmodule
